// File: rtl/adder_seq_pkg.sv
// Shared definitions for the nibble-serial adder: slice width, FSM state type
// and the helper that derives how many slice passes a given width needs.
package adder_seq_pkg;

  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Number of 4-bit passes needed to cover a WIDTH-bit operand.
  function automatic int nib_count(input int width);
    return width / SLICE_W;
  endfunction

endpackage

// File: rtl/adder_slice4.sv
// Combinational 4-bit ripple-carry slice, one full adder per bit.
module adder_slice4
  import adder_seq_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] sum,
  output logic               cout
);

  logic [SLICE_W:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < SLICE_W; i++) begin : g_bit
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[SLICE_W];

endmodule

// File: rtl/adder_seq.sv
// Multi-precision addition sequencer: one 4-bit slice is reused over WIDTH/4
// cycles, least-significant nibble first, with a registered carry between
// passes. Valid/ready handshakes on the operand and result sides.
//
// Optional build macro ADDER_SEQ_SUB_EN adds an in_sub port; when set with the
// operands, B is inverted nibble by nibble and the carry seeds at 1, giving
// A - B with out_cout = 1 meaning no borrow.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | waiting for operands, in_ready high
//   RUN     | one slice pass per cycle, nibble cnt, carry in cy
//   DONE    | result held on out_sum/out_cout until out_ready
module adder_seq
  import adder_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
`ifdef ADDER_SEQ_SUB_EN
  input  logic             in_sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             busy
);

  localparam int NIB   = nib_count(WIDTH);
  localparam int CNT_W = (NIB > 1) ? $clog2(NIB) : 1;

  if ((WIDTH < SLICE_W) || ((WIDTH % SLICE_W) != 0)) begin : g_width_check
    $error("adder_seq: WIDTH must be a multiple of 4 and at least 4");
  end

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               cy_q, cy_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;
`ifdef ADDER_SEQ_SUB_EN
  logic               sub_q, sub_d;
`endif

  logic [SLICE_W-1:0] a_nib, b_nib, slice_sum;
  logic               slice_cout;
  logic               last_nib;

  assign in_ready  = (state_q == ST_IDLE) && !rst;
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign out_sum   = sum_q;
  assign out_cout  = cout_q;
  assign last_nib  = (cnt_q == CNT_W'(NIB - 1));

  // Select the current nibble of each operand; B is inverted when subtracting.
  always_comb begin
    a_nib = a_q[int'(cnt_q) * SLICE_W +: SLICE_W];
    b_nib = b_q[int'(cnt_q) * SLICE_W +: SLICE_W];
`ifdef ADDER_SEQ_SUB_EN
    if (sub_q) begin
      b_nib = ~b_nib;
    end
`endif
  end

  adder_slice4 u_slice (
    .a    (a_nib),
    .b    (b_nib),
    .cin  (cy_q),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  // Next-state and datapath update for the IDLE/RUN/DONE sequencer.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cy_d    = cy_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
`ifdef ADDER_SEQ_SUB_EN
    sub_d   = sub_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready) begin
          a_d     = in_a;
          b_d     = in_b;
          cnt_d   = '0;
          cy_d    = in_cin;
`ifdef ADDER_SEQ_SUB_EN
          sub_d   = in_sub;
          if (in_sub) begin
            cy_d = 1'b1;
          end
`endif
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        sum_d[int'(cnt_q) * SLICE_W +: SLICE_W] = slice_sum;
        cy_d  = slice_cout;
        cnt_d = cnt_q + 1'b1;
        if (last_nib) begin
          cout_d  = slice_cout;
          cnt_d   = '0;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      cy_q    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
`ifdef ADDER_SEQ_SUB_EN
      sub_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cy_q    <= cy_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
`ifdef ADDER_SEQ_SUB_EN
      sub_q   <= sub_d;
`endif
    end
  end

endmodule
